// File: rtl/uart_msg_tx.sv
// UART message transmitter: frames MSG_LEN bytes fetched by index from the parent and
// serialises them LSB first, either periodically with an idle gap or once per trigger.
module uart_msg_tx #(
    parameter int unsigned BAUD_DIV   = 10417,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned MSG_LEN    = 16,
    parameter int unsigned GAP_CYCLES = 20000000,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 trig,
    input  logic [DATA_BITS-1:0] byte_data,
    output logic [IDX_W-1:0]     byte_idx,
    output logic                 busy,
    output logic                 msg_done,
    output logic                 dout
);
    localparam int unsigned TW = $clog2(BAUD_DIV);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0]    T_LAST = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0]    T_PRE  = TW'(BAUD_DIV - 2);
    localparam logic [BW-1:0]    D_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]    S_LAST = BW'(STOP_BITS - 1);
    localparam logic [GW-1:0]    G_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(MSG_LEN - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StGap} state_e;

    state_e               state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt;
    logic [GW-1:0]        gap_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 last_byte;
    logic                 mode_q;

    logic bit_end;
    logic stop_end;
    logic load;

    assign bit_end  = (timer == T_LAST);
    assign stop_end = (state == StStop) && bit_end && (bit_cnt == S_LAST);
    // Every path into a new frame shares one load: from IDLE, between bytes, or after the gap.
    assign load = en && (((state == StIdle) && (!mode || trig)) ||
                         (stop_end && !last_byte) ||
                         ((state == StGap) && (gap_cnt == G_LAST)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            timer     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            last_byte <= 1'b0;
            mode_q    <= 1'b0;
            byte_idx  <= '0;
            busy      <= 1'b0;
            msg_done  <= 1'b0;
            dout      <= 1'b1;
        end else begin
            msg_done <= 1'b0;
            if (load) begin
                state   <= StStart;
                shreg   <= byte_data;
                par_bit <= (PARITY == 2) ? ^byte_data : ~^byte_data;
                timer   <= '0;
                bit_cnt <= '0;
                gap_cnt <= '0;
                busy    <= 1'b1;
                dout    <= 1'b0;
                if (state == StIdle) mode_q <= mode;
            end else begin
                unique case (state)
                    StIdle: begin
                        dout     <= 1'b1;
                        busy     <= 1'b0;
                        byte_idx <= '0;
                    end
                    StStart: begin
                        timer <= bit_end ? '0 : timer + 1'b1;
                        if (bit_end) begin
                            state <= StData;
                            dout  <= shreg[0];
                        end
                    end
                    StData: begin
                        timer <= bit_end ? '0 : timer + 1'b1;
                        if (bit_end) begin
                            if (bit_cnt == D_LAST) begin
                                bit_cnt   <= '0;
                                // Advance early so byte_data settles before the next latch.
                                last_byte <= (byte_idx == I_LAST);
                                byte_idx  <= (byte_idx == I_LAST) ? '0 : byte_idx + 1'b1;
                                if (PARITY != 0) begin
                                    state <= StPar;
                                    dout  <= par_bit;
                                end else begin
                                    state <= StStop;
                                    dout  <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                dout    <= shreg[1];
                                shreg   <= shreg >> 1;
                            end
                        end
                    end
                    StPar: begin
                        timer <= bit_end ? '0 : timer + 1'b1;
                        if (bit_end) begin
                            state <= StStop;
                            dout  <= 1'b1;
                        end
                    end
                    StStop: begin
                        timer <= bit_end ? '0 : timer + 1'b1;
                        if ((timer == T_PRE) && (bit_cnt == S_LAST) && last_byte && en) begin
                            msg_done <= 1'b1;
                        end
                        if (stop_end) begin
                            bit_cnt  <= '0;
                            busy     <= 1'b0;
                            byte_idx <= '0;
                            state    <= (!en || mode_q) ? StIdle : StGap;
                        end else if (bit_end) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    StGap: begin
                        if (!en) begin
                            state   <= StIdle;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx: four instances with different framing, each checked
// cycle by cycle against a bench-side frame model and hand-computed parity bits.
module tb_uart_msg_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic [3:0] rst, en, mode, trig;
    logic [3:0] dout, busy, done;
    logic [1:0] idx0, idx1, idx2;
    logic       idx3;
    logic [7:0] bd0, bd1, bd2;
    logic [6:0] bd3;

    logic [1:0] sel;
    logic       line, bsy, dn;
    logic [1:0] idx;
    logic [2:0] par_seen;

    assign bd0 = (idx0 == 2'd0) ? 8'h55 : (idx0 == 2'd1) ? 8'hA3 : 8'h0F;
    assign bd1 = (idx1 == 2'd0) ? 8'h07 : (idx1 == 2'd1) ? 8'h55 : 8'hA3;
    assign bd2 = (idx2 == 2'd0) ? 8'h07 : (idx2 == 2'd1) ? 8'h00 : 8'hFF;
    assign bd3 = 7'h4B;

    always_comb begin
        line = dout[sel];
        bsy  = busy[sel];
        dn   = done[sel];
        idx  = 2'd0;
        case (sel)
            2'd0:    idx = idx0;
            2'd1:    idx = idx1;
            2'd2:    idx = idx2;
            default: idx = {1'b0, idx3};
        endcase
    end

    uart_msg_tx #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSG_LEN(3),
                  .GAP_CYCLES(10), .IDX_W(2)) u0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .mode(mode[0]), .trig(trig[0]),
        .byte_data(bd0), .byte_idx(idx0), .busy(busy[0]), .msg_done(done[0]), .dout(dout[0]));

    uart_msg_tx #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .MSG_LEN(3),
                  .GAP_CYCLES(10), .IDX_W(2)) u1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .mode(mode[1]), .trig(trig[1]),
        .byte_data(bd1), .byte_idx(idx1), .busy(busy[1]), .msg_done(done[1]), .dout(dout[1]));

    uart_msg_tx #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MSG_LEN(3),
                  .GAP_CYCLES(10), .IDX_W(2)) u2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .mode(mode[2]), .trig(trig[2]),
        .byte_data(bd2), .byte_idx(idx2), .busy(busy[2]), .msg_done(done[2]), .dout(dout[2]));

    uart_msg_tx #(.BAUD_DIV(2), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .MSG_LEN(1),
                  .GAP_CYCLES(10), .IDX_W(1)) u3 (
        .clk(clk), .rst(rst[3]), .en(en[3]), .mode(mode[3]), .trig(trig[3]),
        .byte_data(bd3), .byte_idx(idx3), .busy(busy[3]), .msg_done(done[3]), .dout(dout[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level at bit position p of a frame: start, data LSB first, optional parity, stops.
    function automatic logic frame_bit(input logic [7:0] b, input int db, input int par,
                                       input int p);
        logic x;
        x = 1'b0;
        if (p == 0) return 1'b0;
        if (p <= db) return b[p-1];
        if (par != 0 && p == db + 1) begin
            for (int i = 0; i < db; i++) x = x ^ b[i];
            return (par == 2) ? x : ~x;
        end
        return 1'b1;
    endfunction

    // Checks nbytes back-to-back frames; cycle k=1 is the first cycle after the start edge.
    task automatic check_msg(input string tag, input int nbytes, input int db, input int par,
                             input int stops, input int baud, input logic [23:0] bytes,
                             input bit want_done);
        int flen, total, j, p;
        flen  = (1 + db + ((par != 0) ? 1 : 0) + stops) * baud;
        total = nbytes * flen;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            j = (k - 1) / flen;
            p = ((k - 1) % flen) / baud;
            chk($sformatf("%s dout k=%0d", tag, k), {31'd0, line},
                {31'd0, frame_bit(bytes[8*j +: 8], db, par, p)});
            chk($sformatf("%s busy k=%0d", tag, k), {31'd0, bsy}, 32'd1);
            chk($sformatf("%s msg_done k=%0d", tag, k), {31'd0, dn},
                {31'd0, (want_done && k == total)});
            if (par != 0 && p == db + 1) par_seen[j] = line;
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("%s dout k=%0d", tag, k), {31'd0, line}, 32'd1);
            chk($sformatf("%s busy k=%0d", tag, k), {31'd0, bsy}, 32'd0);
            chk($sformatf("%s msg_done k=%0d", tag, k), {31'd0, dn}, 32'd0);
            chk($sformatf("%s byte_idx k=%0d", tag, k), {30'd0, idx}, 32'd0);
        end
    endtask

    initial begin
        rst = 4'h0; en = 4'h0; mode = 4'h0; trig = 4'h0;
        sel = 2'd0; par_seen = 3'b000;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            chk($sformatf("reset dout u%0d", i), {31'd0, line}, 32'd1);
            chk($sformatf("reset busy u%0d", i), {31'd0, bsy}, 32'd0);
            chk($sformatf("reset msg_done u%0d", i), {31'd0, dn}, 32'd0);
            chk($sformatf("reset byte_idx u%0d", i), {30'd0, idx}, 32'd0);
        end
        @(negedge clk);
        rst = 4'hF;

        // Periodic mode, no parity: three 40-cycle frames, 10-cycle gap, restart.
        sel = 2'd0;
        idle_check("t1 pre", 3);
        en[0] = 1'b1;
        check_msg("t1 msg", 3, 8, 0, 1, 4, 24'h0FA355, 1'b1);
        idle_check("t1 gap", 10);
        check_msg("t1 again", 3, 8, 0, 1, 4, 24'h0FA355, 1'b1);
        en[0] = 1'b0;
        idle_check("t1 off", 5);

        // en dropped in byte 1 data: byte 1 finishes, then idle with no msg_done.
        en[0] = 1'b1;
        fork
            check_msg("t4 msg", 2, 8, 0, 1, 4, 24'h00A355, 1'b0);
            begin
                repeat (50) @(negedge clk);
                en[0] = 1'b0;
            end
        join
        idle_check("t4 idle", 10);

        // Reset mid-data while the line is low, then restart from byte 0.
        en[0] = 1'b1;
        repeat (9) @(negedge clk);
        chk("t5 dout low before reset", {31'd0, line}, 32'd0);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("t5 reset dout", {31'd0, line}, 32'd1);
        chk("t5 reset busy", {31'd0, bsy}, 32'd0);
        chk("t5 reset byte_idx", {30'd0, idx}, 32'd0);
        chk("t5 reset msg_done", {31'd0, dn}, 32'd0);
        rst[0] = 1'b1;
        check_msg("t5 restart", 3, 8, 0, 1, 4, 24'h0FA355, 1'b1);
        en[0] = 1'b0;

        // Single-shot, even parity, two stop bits: one 3x48 message; trig while busy ignored.
        sel = 2'd1;
        mode[1] = 1'b1;
        en[1] = 1'b1;
        idle_check("t3 wait", 5);
        par_seen = 3'b000;
        trig[1] = 1'b1;
        fork
            check_msg("t3 msg", 3, 8, 2, 2, 4, 24'hA35507, 1'b1);
            begin
                @(negedge clk);
                trig[1] = 1'b0;
                repeat (30) @(negedge clk);
                trig[1] = 1'b1;
                @(negedge clk);
                trig[1] = 1'b0;
            end
        join
        chk("t2 even parity bits", {29'd0, par_seen}, 32'h1);
        idle_check("t3 after", 20);

        // Odd parity, 44-cycle frames.
        sel = 2'd2;
        mode[2] = 1'b1;
        en[2] = 1'b1;
        par_seen = 3'b000;
        trig[2] = 1'b1;
        fork
            check_msg("t2 odd msg", 3, 8, 1, 1, 4, 24'hFF0007, 1'b1);
            begin
                @(negedge clk);
                trig[2] = 1'b0;
            end
        join
        chk("t2 odd parity bits", {29'd0, par_seen}, 32'h6);
        idle_check("t2 odd after", 5);

        // 7 data bits, BAUD_DIV=2, one-byte message: 18-cycle frames each with msg_done.
        sel = 2'd3;
        en[3] = 1'b1;
        check_msg("t6 frame", 1, 7, 0, 1, 2, 24'h00004B, 1'b1);
        idle_check("t6 gap", 10);
        check_msg("t6 frame2", 1, 7, 0, 1, 2, 24'h00004B, 1'b1);
        en[3] = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
